// File: rtl/led_pattern_seq_pkg.sv
// Shared types and constant helpers for the LED pattern sequencer.
package led_pattern_seq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Bits needed to hold 0..v-1, never less than one.
  function automatic int clog2_min1(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/led_pattern_seq_tick_gen.sv
// Step divider: counts 0..DIV-1 while enabled, strobes oTICK on the last count.
module tick_gen
  import led_pattern_seq_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic iCLK,
  input  logic iRST_N,
  input  logic iCLR,
  input  logic iEN,
  output logic oTICK
);

  localparam int W = clog2_min1(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (iCLR)     cnt_d = '0;
    else if (iEN) cnt_d = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign oTICK = iEN && !iCLR && (cnt_q == LAST);

endmodule

// File: rtl/led_pattern_seq.sv
// Multi-channel LED pattern sequencer: plays a latched PAT_LEN-step pattern, TICK_DIV cycles per step.
module led_pattern_seq
  import led_pattern_seq_pkg::*;
#(
  parameter int TICK_DIV = 5000000,
  parameter int PAT_LEN  = 12,
  parameter int CH       = 1
) (
  input  logic                            iCLK,
  input  logic                            iRST_N,
  input  logic [CH*PAT_LEN-1:0]           iPATTERN,
  input  logic                            iMODE,
  input  logic                            iSTART,
  input  logic                            iSTOP,
  input  logic                            iHOLD,
  output logic [CH-1:0]                   oLED,
  output logic [clog2_min1(PAT_LEN)-1:0]  oSTEP,
  output logic                            oBUSY,
  output logic                            oDONE
);

  localparam int SW = clog2_min1(PAT_LEN);
  localparam logic [SW-1:0] LAST_STEP = SW'(PAT_LEN - 1);

  state_e                state_q, state_d;
  logic [CH*PAT_LEN-1:0] pat_q, pat_d;
  logic                  mode_q, mode_d;
  logic [SW-1:0]         step_q, step_d;
  logic [CH-1:0]         led_q, led_d;
  logic                  done_q, done_d;

  logic tick, div_clr, div_en, last_strobe;

  assign div_clr     = iSTART || iSTOP || (state_q == IDLE);
  assign div_en      = (state_q == RUN) && !iHOLD;
  assign last_strobe = (state_q == RUN) && tick && (step_q == LAST_STEP);

  tick_gen #(.DIV(TICK_DIV)) u_tick (
    .iCLK  (iCLK),
    .iRST_N(iRST_N),
    .iCLR  (div_clr),
    .iEN   (div_en),
    .oTICK (tick)
  );

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Stop beats start, start beats the final one-shot strobe.
  always_comb begin
    state_d = state_q;
    if (iSTOP)                     state_d = IDLE;
    else if (iSTART)               state_d = RUN;
    else if (last_strobe && mode_q) state_d = IDLE;
  end

  always_comb begin
    pat_d  = pat_q;
    mode_d = mode_q;
    step_d = step_q;
    led_d  = led_q;
    done_d = 1'b0;
    if (iSTOP) begin
      step_d = '0;
      led_d  = '0;
    end else if (iSTART) begin
      pat_d  = iPATTERN;
      mode_d = iMODE;
      step_d = '0;
      led_d  = iPATTERN[CH-1:0];
    end else if (last_strobe) begin
      step_d = '0;
      if (mode_q) begin
        led_d  = '0;
        done_d = 1'b1;
      end else begin
        led_d  = pat_q[CH-1:0];
      end
    end else if ((state_q == RUN) && tick) begin
      step_d = step_q + SW'(1);
      led_d  = pat_q[(int'(step_q) + 1) * CH +: CH];
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      pat_q  <= '0;
      mode_q <= 1'b0;
      step_q <= '0;
      led_q  <= '0;
      done_q <= 1'b0;
    end else begin
      pat_q  <= pat_d;
      mode_q <= mode_d;
      step_q <= step_d;
      led_q  <= led_d;
      done_q <= done_d;
    end
  end

  assign oLED  = led_q;
  assign oSTEP = step_q;
  assign oBUSY = (state_q == RUN);
  assign oDONE = done_q;

endmodule

// File: tb/tb_led_pattern_seq.sv
// Bench: table vectors on a 2-channel single-cycle instance, model-checked directed and random runs on a 1-channel instance.
module tb_led_pattern_seq;

  localparam int TDA = 4;
  localparam int PL  = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // instance A: TICK_DIV=4, CH=1
  logic [11:0] a_pat;
  logic        a_mode, a_start, a_stop, a_hold;
  logic [0:0]  a_led;
  logic [3:0]  a_step;
  logic        a_busy, a_done;

  // instance B: TICK_DIV=1, CH=2
  logic [23:0] b_pat;
  logic        b_mode, b_start, b_stop, b_hold;
  logic [1:0]  b_led;
  logic [3:0]  b_step;
  logic        b_busy, b_done;

  led_pattern_seq #(.TICK_DIV(TDA), .PAT_LEN(PL), .CH(1)) dut_a (
    .iCLK(clk), .iRST_N(rst_n), .iPATTERN(a_pat), .iMODE(a_mode),
    .iSTART(a_start), .iSTOP(a_stop), .iHOLD(a_hold),
    .oLED(a_led), .oSTEP(a_step), .oBUSY(a_busy), .oDONE(a_done)
  );

  led_pattern_seq #(.TICK_DIV(1), .PAT_LEN(PL), .CH(2)) dut_b (
    .iCLK(clk), .iRST_N(rst_n), .iPATTERN(b_pat), .iMODE(b_mode),
    .iSTART(b_start), .iSTOP(b_stop), .iHOLD(b_hold),
    .oLED(b_led), .oSTEP(b_step), .oBUSY(b_busy), .oDONE(b_done)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference model for A: elapsed un-held cycles since start; step = elapsed / TICK_DIV.
  logic        m_busy, m_mode, m_done;
  logic [11:0] m_pat;
  int          m_el;

  task automatic model_reset();
    m_busy = 0; m_mode = 0; m_done = 0; m_pat = '0; m_el = 0;
  endtask

  task automatic model_edge();
    m_done = 0;
    if (a_stop) begin
      m_busy = 0; m_el = 0;
    end else if (a_start) begin
      m_busy = 1; m_pat = a_pat; m_mode = a_mode; m_el = 0;
    end else if (m_busy && !a_hold) begin
      m_el++;
      if (m_el == PL * TDA) begin
        m_el = 0;
        if (m_mode) begin m_busy = 0; m_done = 1; end
      end
    end
  endtask

  task automatic cmp_a(input string tag);
    int s;
    s = m_busy ? m_el / TDA : 0;
    chk({tag, ".busy"}, 32'(a_busy), 32'(m_busy));
    chk({tag, ".step"}, 32'(a_step), 32'(s));
    chk({tag, ".led"},  32'(a_led),  m_busy ? 32'(m_pat[s]) : 32'd0);
    chk({tag, ".done"}, 32'(a_done), 32'(m_done));
  endtask

  task automatic step_a(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cmp_a(tag);
  endtask

  typedef struct {
    logic       start, stop, mode;
    logic       busy;
    logic [3:0] step;
    logic [1:0] led;
    logic       done;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic st, sp, md, bz, input logic [3:0] s, input logic [1:0] l, input logic d);
    vec_t v;
    v.start = st; v.stop = sp; v.mode = md; v.busy = bz; v.step = s; v.led = l; v.done = d;
    tbl.push_back(v);
  endtask

  initial begin
    int e1[12] = '{1, 1, 1, 0, 0, 1, 1, 0, 0, 1, 0, 0};
    int n, cnt3;
    bit seen;

    a_pat = 12'h267; a_mode = 0; a_start = 0; a_stop = 0; a_hold = 0;
    b_pat = 24'hE41B2C; b_mode = 0; b_start = 0; b_stop = 0; b_hold = 0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cmp_a("reset_a");
    chk("reset_b.busy", 32'(b_busy), 0);
    chk("reset_b.led",  32'(b_led),  0);
    chk("reset_b.step", 32'(b_step), 0);

    // B: step s, channel c = bit 2s+c of 24'hE41B2C
    add(1,0,0, 1,0,2'b00,0);
    add(0,0,0, 1,1,2'b11,0); add(0,0,0, 1,2,2'b10,0); add(0,0,0, 1,3,2'b00,0);
    add(0,0,0, 1,4,2'b11,0); add(0,0,0, 1,5,2'b10,0); add(0,0,0, 1,6,2'b01,0);
    add(0,0,0, 1,7,2'b00,0);
    add(1,0,0, 1,0,2'b00,0);
    add(0,0,0, 1,1,2'b11,0);
    add(0,1,0, 0,0,2'b00,0);
    add(1,1,0, 0,0,2'b00,0);
    add(1,0,1, 1,0,2'b00,0);
    add(0,0,0, 1,1,2'b11,0);  add(0,0,0, 1,2,2'b10,0);  add(0,0,0, 1,3,2'b00,0);
    add(0,0,0, 1,4,2'b11,0);  add(0,0,0, 1,5,2'b10,0);  add(0,0,0, 1,6,2'b01,0);
    add(0,0,0, 1,7,2'b00,0);  add(0,0,0, 1,8,2'b00,0);  add(0,0,0, 1,9,2'b01,0);
    add(0,0,0, 1,10,2'b10,0); add(0,0,0, 1,11,2'b11,0);
    add(0,0,0, 0,0,2'b00,1);
    add(0,0,0, 0,0,2'b00,0);
    foreach (tbl[i]) begin
      b_start = tbl[i].start; b_stop = tbl[i].stop; b_mode = tbl[i].mode;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vecB%0d.busy", i), 32'(b_busy), 32'(tbl[i].busy));
      chk($sformatf("vecB%0d.step", i), 32'(b_step), 32'(tbl[i].step));
      chk($sformatf("vecB%0d.led", i),  32'(b_led),  32'(tbl[i].led));
      chk($sformatf("vecB%0d.done", i), 32'(b_done), 32'(tbl[i].done));
    end
    b_start = 0; b_stop = 0;

    // loop mode sequence
    a_start = 1; a_mode = 0;
    step_a("loop_start");
    a_start = 0;
    for (int s = 0; s < 12; s++) begin
      chk($sformatf("loop_led%0d", s), 32'(a_led), 32'(e1[s]));
      chk($sformatf("loop_step%0d", s), 32'(a_step), 32'(s));
      repeat (TDA) step_a("loop");
    end
    chk("loop_wrap_step", 32'(a_step), 0);
    chk("loop_wrap_led", 32'(a_led), 1);

    // one-shot: done after exactly 48 cycles
    a_start = 1; a_mode = 1;
    step_a("os_start");
    a_start = 0;
    n = 0; seen = 0;
    while (!seen && n < 100) begin
      step_a("os");
      n++;
      if (a_done) seen = 1;
    end
    chk("os_done_cycles", 32'(n), 48);
    step_a("os_after");
    chk("os_done_pulse", 32'(a_done), 0);
    chk("os_idle", 32'(a_busy), 0);

    // stop at step 5
    a_start = 1; a_mode = 0;
    step_a("stop_start");
    a_start = 0;
    n = 0;
    while (a_step != 5 && n < 100) begin step_a("stop_run"); n++; end
    chk("stop_reach5", 32'(a_step), 5);
    a_stop = 1;
    step_a("stop");
    a_stop = 0;
    chk("stop_busy", 32'(a_busy), 0);
    chk("stop_done", 32'(a_done), 0);
    a_start = 1; a_stop = 1;
    step_a("startstop_idle");
    a_start = 0; a_stop = 0;
    chk("startstop_busy", 32'(a_busy), 0);

    // hold on the 2nd cycle of step 3 for 10 cycles
    a_start = 1; a_mode = 0;
    step_a("hold_start");
    a_start = 0;
    n = 0;
    while (a_step != 3 && n < 100) begin step_a("hold_run"); n++; end
    cnt3 = 1;
    step_a("hold_pre");
    if (a_step == 3) cnt3++;
    a_hold = 1;
    repeat (10) begin step_a("hold"); if (a_step == 3) cnt3++; end
    a_hold = 0;
    n = 0;
    while (a_step == 3 && n < 100) begin step_a("hold_rel"); n++; if (a_step == 3) cnt3++; end
    chk("hold_len", 32'(cnt3), 14);
    chk("hold_next", 32'(a_step), 4);

    // randomized run against the model
    for (int i = 0; i < 2500; i++) begin
      a_start = ($urandom_range(0, 19) == 0);
      a_stop  = ($urandom_range(0, 59) == 0);
      a_hold  = ($urandom_range(0, 4) == 0);
      a_mode  = $urandom_range(0, 1);
      a_pat   = 12'($urandom);
      step_a("rand");
    end
    a_start = 0; a_stop = 0; a_hold = 0;

    // async reset mid-run, between edges
    a_start = 1; a_mode = 0; a_pat = 12'h267;
    step_a("rst_start");
    a_start = 0;
    repeat (9) step_a("rst_run");
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    cmp_a("async_rst");
    #1 rst_n = 1'b1;
    repeat (8) step_a("post_rst");
    chk("post_rst_idle", 32'(a_busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
